// File: rtl/ps2_mouse_pkg.sv
// PS/2 mouse receiver shared definitions.
// FSM encodings, frame geometry and packet sync-bit position.
package ps2_mouse_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam int TIMEOUT_DEFAULT = 5000;
  localparam int FRAME_LEN       = 11;
  localparam int DATA_BITS       = FRAME_LEN - 3;
  localparam int SYNC_BIT        = 3;

endpackage

// File: rtl/ps2_mouse_packet_asm.sv
// Assembles three good bytes into a mouse movement packet.
// Fed with next-cycle byte strobes so pkt_valid aligns with byte_valid.
module ps2_mouse_packet_asm
  import ps2_mouse_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  input  logic       frame_err,
  input  logic       pkt_enable,
  output logic [7:0] pkt_status,
  output logic [7:0] pkt_dx,
  output logic [7:0] pkt_dy,
  output logic       pkt_valid
);

  logic [1:0] idx_q, idx_d;
  logic [7:0] b0_q, b0_d;
  logic [7:0] b1_q, b1_d;
  logic [7:0] st_q, st_d;
  logic [7:0] dx_q, dx_d;
  logic [7:0] dy_q, dy_d;
  logic       pv_q, pv_d;

  always_comb begin
    idx_d = idx_q;
    b0_d  = b0_q;
    b1_d  = b1_q;
    st_d  = st_q;
    dx_d  = dx_q;
    dy_d  = dy_q;
    pv_d  = 1'b0;
    if (frame_err) begin
      idx_d = 2'd0;
    end else if (byte_valid && !pkt_enable) begin
      idx_d = 2'd0;
    end else if (byte_valid) begin
      case (idx_q)
        2'd0: begin
          // Bytes without the sync bit cannot start a packet.
          if (byte_data[SYNC_BIT]) begin
            b0_d  = byte_data;
            idx_d = 2'd1;
          end
        end
        2'd1: begin
          b1_d  = byte_data;
          idx_d = 2'd2;
        end
        default: begin
          st_d  = b0_q;
          dx_d  = b1_q;
          dy_d  = byte_data;
          pv_d  = 1'b1;
          idx_d = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= 2'd0;
      b0_q  <= 8'h00;
      b1_q  <= 8'h00;
      st_q  <= 8'h00;
      dx_q  <= 8'h00;
      dy_q  <= 8'h00;
      pv_q  <= 1'b0;
    end else begin
      idx_q <= idx_d;
      b0_q  <= b0_d;
      b1_q  <= b1_d;
      st_q  <= st_d;
      dx_q  <= dx_d;
      dy_q  <= dy_d;
      pv_q  <= pv_d;
    end
  end

  assign pkt_status = st_q;
  assign pkt_dx     = dx_q;
  assign pkt_dy     = dy_q;
  assign pkt_valid  = pv_q;

endmodule

// File: rtl/ps2_mouse_frame_rx.sv
// PS/2 frame receiver: start, 8 data LSB first, odd parity, stop.
// Inter-edge timeout aborts stalled frames; packets built downstream.
module ps2_mouse_frame_rx
  import ps2_mouse_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       falling_edge,
  input  logic       ps2_data,
  input  logic       pkt_enable,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic [7:0] pkt_status,
  output logic [7:0] pkt_dx,
  output logic [7:0] pkt_dy,
  output logic       pkt_valid,
  output logic       busy
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

  logic [1:0]    state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    byte_q, byte_d;
  logic          bv_q, bv_d;
  logic          err_q, err_d;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tmo_d    = tmo_q;
    byte_d   = byte_q;
    bv_d     = 1'b0;
    err_d    = 1'b0;
    if (state_q != ST_IDLE && !falling_edge) begin
      if (tmo_q == TMO_LAST) begin
        state_d = ST_IDLE;
        tmo_d   = '0;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
    // An edge always beats an expiring timeout.
    if (falling_edge) begin
      tmo_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (!ps2_data) begin
            state_d  = ST_DATA;
            bitcnt_d = 3'd0;
            shift_d  = 8'h00;
          end
        end
        ST_DATA: begin
          shift_d  = {ps2_data, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == BIT_LAST) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          par_d   = ps2_data;
          state_d = ST_STOP;
        end
        default: begin
          state_d = ST_IDLE;
          if ((^{shift_q, par_q}) && ps2_data) begin
            byte_d = shift_q;
            bv_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= 3'd0;
      shift_q  <= 8'h00;
      par_q    <= 1'b0;
      tmo_q    <= '0;
      byte_q   <= 8'h00;
      bv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tmo_q    <= tmo_d;
      byte_q   <= byte_d;
      bv_q     <= bv_d;
      err_q    <= err_d;
    end
  end

  assign byte_data  = byte_q;
  assign byte_valid = bv_q;
  assign frame_err  = err_q;
  assign busy       = (state_q != ST_IDLE);

  ps2_mouse_packet_asm u_pkt (
    .clk        (clk),
    .reset      (reset),
    .byte_data  (byte_d),
    .byte_valid (bv_d),
    .frame_err  (err_d),
    .pkt_enable (pkt_enable),
    .pkt_status (pkt_status),
    .pkt_dx     (pkt_dx),
    .pkt_dy     (pkt_dy),
    .pkt_valid  (pkt_valid)
  );

endmodule

// File: tb/tb_ps2_mouse_frame_rx.sv
// Directed bench for ps2_mouse_frame_rx with byte/packet scoreboards.
// A negedge monitor pops expectations whenever the DUT pulses.
module tb_ps2_mouse_frame_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       falling_edge = 1'b0;
  logic       ps2_data = 1'b1;
  logic       pkt_enable = 1'b0;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       frame_err;
  logic [7:0] pkt_status;
  logic [7:0] pkt_dx;
  logic [7:0] pkt_dy;
  logic       pkt_valid;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int err_exp = 0;

  logic [7:0]  byte_q[$];
  logic [23:0] pkt_q[$];

  logic bv_prev = 1'b0;
  logic fe_prev = 1'b0;
  logic pv_prev = 1'b0;

  ps2_mouse_frame_rx dut (
    .clk          (clk),
    .reset        (reset),
    .falling_edge (falling_edge),
    .ps2_data     (ps2_data),
    .pkt_enable   (pkt_enable),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .frame_err    (frame_err),
    .pkt_status   (pkt_status),
    .pkt_dx       (pkt_dx),
    .pkt_dy       (pkt_dy),
    .pkt_valid    (pkt_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (byte_valid) begin
      if (byte_q.size() > 0) chk("byte_data", byte_data, byte_q.pop_front());
      else chk("byte_unexpected", byte_valid, 0);
      chk("byte_valid_width", bv_prev, 0);
    end
    if (pkt_valid) begin
      if (pkt_q.size() > 0)
        chk("packet", {pkt_status, pkt_dx, pkt_dy}, pkt_q.pop_front());
      else chk("pkt_unexpected", pkt_valid, 0);
      chk("pkt_valid_width", pv_prev, 0);
    end
    if (frame_err) begin
      if (err_exp > 0) err_exp--;
      else chk("err_unexpected", frame_err, 0);
      chk("frame_err_width", fe_prev, 0);
    end
    bv_prev = byte_valid;
    fe_prev = frame_err;
    pv_prev = pkt_valid;
  end

  task automatic edge_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    falling_edge = 1'b1;
    @(negedge clk);
    falling_edge = 1'b0;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par,
                            input logic stop);
    edge_bit(1'b0);
    for (int i = 0; i < 8; i++) edge_bit(b[i]);
    edge_bit((~^b) ^ bad_par);
    edge_bit(stop);
  endtask

  task automatic good_byte(input logic [7:0] b);
    byte_q.push_back(b);
    send_frame(b, 1'b0, 1'b1);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_byte_data", byte_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt", {pkt_status, pkt_dx, pkt_dy}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Byte-only mode
    pkt_enable = 1'b0;
    good_byte(8'h08);
    chk("hold_byte_08", byte_data, 8'h08);
    chk("idle_busy", busy, 0);

    // Full packet
    pkt_enable = 1'b1;
    good_byte(8'h08);
    good_byte(8'h05);
    pkt_q.push_back({8'h08, 8'h05, 8'hFB});
    good_byte(8'hFB);

    // Bad parity
    pkt_enable = 1'b0;
    err_exp++;
    send_frame(8'hFA, 1'b1, 1'b1);
    chk("bad_par_hold", byte_data, 8'hFB);
    chk("bad_par_busy", busy, 0);
    chk("bad_par_err_seen", err_exp, 0);

    // Timeout after start plus four bits
    err_exp++;
    edge_bit(1'b0);
    for (int i = 0; i < 4; i++) edge_bit(1'b1);
    chk("tmo_busy_mid", busy, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_err && n < 6000);
    chk("tmo_latency", n, 4997);
    chk("tmo_busy", busy, 0);
    repeat (2) @(negedge clk);
    good_byte(8'h00);
    chk("after_tmo_byte", byte_data, 8'h00);

    // Sync-bit drop then packet
    pkt_enable = 1'b1;
    good_byte(8'h00);
    good_byte(8'h08);
    good_byte(8'h01);
    pkt_q.push_back({8'h08, 8'h01, 8'h02});
    good_byte(8'h02);
    chk("pkt_hold_dy", pkt_dy, 8'h02);

    // Reset mid-frame
    edge_bit(1'b0);
    for (int i = 0; i < 5; i++) edge_bit(1'b1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_byte", byte_data, 0);
    chk("mid_rst_pkt", {pkt_status, pkt_dx, pkt_dy}, 0);
    chk("mid_rst_busy", busy, 0);
    good_byte(8'hAA);
    chk("after_rst_byte", byte_data, 8'hAA);

    repeat (10) @(negedge clk);
    chk("byte_q_empty", byte_q.size(), 0);
    chk("pkt_q_empty", pkt_q.size(), 0);
    chk("err_all_seen", err_exp, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
